// File: rtl/dot8_lane_packer.sv
// Packs a serial stream of (a,b) element pairs into 8-lane groups for the dot unit.
// Define DOT8_PACK_STATS_EN to add the grp_count / vec_count / pad_lanes statistics outputs.
module dot8_lane_packer #(
    parameter int IWIDTH = 8,
    parameter int LANES  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IWIDTH-1:0]       in_a,
    input  logic [IWIDTH-1:0]       in_b,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [LANES*IWIDTH-1:0] vec0,
    output logic [LANES*IWIDTH-1:0] vec1,
    output logic                    ovalid,
    output logic                    olast
`ifdef DOT8_PACK_STATS_EN
    ,
    output logic [31:0]             grp_count,
    output logic [31:0]             vec_count,
    output logic [2:0]              pad_lanes
`endif
);
    localparam int IDXW = $clog2(LANES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    typedef enum logic {FILL, GAP} state_e;
    // Index LANES-1 is the top slice, so lane k lives at index LANES-1-k.
    typedef logic [LANES-1:0][IWIDTH-1:0] lanes_t;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    lanes_t          a_buf_q, a_buf_d, b_buf_q, b_buf_d;
    lanes_t          a_merge, b_merge;
    lanes_t          vec0_q, vec0_d, vec1_q, vec1_d;
    logic            ovalid_q, ovalid_d, olast_q, olast_d;
    logic            accept, emit;
    logic [IDXW-1:0] lane_sel;

    assign in_ready = (state_q == FILL) && !rst;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && ((idx_q == LAST_IDX) || in_last);
    assign lane_sel = LAST_IDX - idx_q;

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        vec0_d   = vec0_q;
        vec1_d   = vec1_q;
        ovalid_d = 1'b0;
        olast_d  = 1'b0;

        a_merge           = a_buf_q;
        b_merge           = b_buf_q;
        a_merge[lane_sel] = in_a;
        b_merge[lane_sel] = in_b;

        case (state_q)
            FILL: begin
                if (emit) begin
                    vec0_d   = a_merge;
                    vec1_d   = b_merge;
                    a_buf_d  = '0;
                    b_buf_d  = '0;
                    idx_d    = '0;
                    ovalid_d = 1'b1;
                    olast_d  = in_last;
                    if (in_last) state_d = GAP;
                end else if (accept) begin
                    a_buf_d = a_merge;
                    b_buf_d = b_merge;
                    idx_d   = idx_q + 1'b1;
                end
            end
            // One-cycle bubble so the downstream accumulator sees vectors apart.
            GAP:     state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values; the
        // assembly buffers are small registers, not RAM, so they are reset along with the rest.
        if (rst) begin
            state_q  <= FILL;
            idx_q    <= '0;
            a_buf_q  <= '0;
            b_buf_q  <= '0;
            vec0_q   <= '0;
            vec1_q   <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_buf_q  <= a_buf_d;
            b_buf_q  <= b_buf_d;
            vec0_q   <= vec0_d;
            vec1_q   <= vec1_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

    assign vec0   = vec0_q;
    assign vec1   = vec1_q;
    assign ovalid = ovalid_q;
    assign olast  = olast_q;

`ifdef DOT8_PACK_STATS_EN
    logic [31:0] grp_count_q, vec_count_q;
    logic [2:0]  pad_lanes_q;

    // Lanes above the emitting index are the padded ones, which is exactly lane_sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_count_q <= '0;
            vec_count_q <= '0;
            pad_lanes_q <= '0;
        end else if (emit) begin
            grp_count_q <= grp_count_q + 32'd1;
            if (in_last) vec_count_q <= vec_count_q + 32'd1;
            pad_lanes_q <= 3'(lane_sel);
        end
    end

    assign grp_count = grp_count_q;
    assign vec_count = vec_count_q;
    assign pad_lanes = pad_lanes_q;
`endif

endmodule
